cnn_frame_sequencer: RTL and testbench
======================================

# cnn_frame_sequencer

Parametrised frame-level controller for the CNN accelerator. It accepts one image, plus a label byte in training mode, over a byte stream and holds the image in an internal pixel buffer that the layer engines read. It then sequences the forward and, in training, backward passes through start/done handshakes, reduces the streamed logits to an argmax class, and returns the result through a valid/ready output with timeout and error reporting.

## Interface
Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- NUM_CLASSES, 10, logits per frame (≥2)
- LOGIT_W, 16, signed logit width
- TIMEOUT, 65535, max cycles waiting for fwd_done/bwd_done
- derived: NPIX=IMG_W*IMG_H, AW=clog2(NPIX), CW=clog2(NUM_CLASSES)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  8  pixel/label byte
- s_valid  in  1  s_data valid
- s_ready  out  1  sequencer accepts byte (transfer = s_valid & s_ready)
- mode_train  in  1  1=training, 0=inference; sampled per frame
- pix_rd_addr  in  AW  engine read address (row-major, y*IMG_W+x)
- pix_rd_data  out  8  buffer data, 1-cycle read latency
- label_out  out  8  label of current frame
- fwd_start  out  1  one-cycle pulse, start forward pass
- fwd_done  in  1  forward pass complete
- bwd_start  out  1  one-cycle pulse, start backward pass
- bwd_done  in  1  backward pass complete
- logit_data  in  LOGIT_W  signed logit, streamed in class order 0..NUM_CLASSES-1
- logit_valid  in  1  logit_data valid
- m_class  out  CW  argmax class index
- m_score  out  LOGIT_W  winning logit
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- err_timeout  out  1  sticky: done not received within TIMEOUT
- err_logit  out  1  sticky: logit count ≠ NUM_CLASSES at fwd_done
- err_clr  in  1  clears both error flags
- frame_cnt  out  16  completed frames, wraps at 65535→0

## Operation
- States: LOAD, LABEL, FWD, BWD, OUT. Reset state LOAD.
- LOAD: s_ready=1. Each transfer writes s_data at wr_ptr, then wr_ptr+1. mode_train is latched on the first pixel of the frame; later changes are ignored until the next frame. After pixel NPIX-1: go to LABEL if latched train=1, else FWD. wr_ptr returns to 0.
- LABEL: s_ready=1. One transfer loads label_out, then go to FWD.
- FWD: s_ready=0. fwd_start pulses in the first FWD cycle. Clear logit count, best index, and best score on entry.
  - Each logit_valid: if count<NUM_CLASSES, compare signed; replace best only if strictly greater, so ties keep the lower index. Logit 0 always loads best. Count increments, saturating at NUM_CLASSES+1.
  - On fwd_done with count==NUM_CLASSES: go to BWD if train, else OUT.
  - On fwd_done with count≠NUM_CLASSES: set err_logit, discard the frame, go to LOAD.
  - A logit_valid in the same cycle as fwd_done is counted first.
- BWD: bwd_start pulses in the first BWD cycle. On bwd_done go to OUT.
- Timeout: a cycle counter restarts on FWD/BWD entry. If TIMEOUT cycles elapse with no done: set err_timeout, discard the frame, go to LOAD. No m_valid is produced.
- OUT: m_valid=1. m_class and m_score stay stable until m_ready. On handshake: frame_cnt+1, go to LOAD.
- pix_rd_data reads the buffer in every state. A read of the address being written in the same cycle returns the old data.
- err_clr clears the flags. If err_clr and a set condition occur in the same cycle, set wins.
- Reset mid-frame discards the partial frame.

## Timing
- Reset values: s_ready=1, fwd_start=0, bwd_start=0, m_valid=0, m_class=0, m_score=0, label_out=0, err_timeout=0, err_logit=0, frame_cnt=0, pix_rd_data=0. The buffer contents are not reset.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- The last pixel (or the label) is accepted in cycle N; fwd_start=1 in cycle N+1.
- fwd_done/bwd_done are honoured from the cycle after the start pulse onward. A done in the same cycle as the start pulse is ignored.
- Inference: fwd_done in cycle N gives m_valid=1 in N+1. Training: bwd_start in N+1, and bwd_done in M gives m_valid in M+1.
- m_ready together with m_valid in cycle N: m_valid=0 and s_ready=1 in N+1.
- Timeout fires when the wait counter reaches TIMEOUT. The state is LOAD in the next cycle.

## Test plan
- Inference, 4x4 image (IMG_W=IMG_H=4), pixels 0..15, logits {3,-7,12,12,0,...} -> m_class=2, m_score=12, m_valid the cycle after fwd_done; pix_rd_addr=9 returns 9 one cycle later.
- Training: 16 pixels then label 0x05 -> label_out=5. Also check bwd_start one cycle after fwd_done, m_valid one cycle after bwd_done, and frame_cnt=1 after the handshake.
- All-negative logits {-1,-5,...,-100}, with m_ready held low for 20 cycles -> m_class=0, m_score=-1, result stable; s_ready=0 throughout.
- 9 logits then fwd_done (NUM_CLASSES=10) -> err_logit=1, no m_valid, back to LOAD. Then err_clr -> err_logit=0.
- TIMEOUT=50, fwd_done never asserted -> err_timeout=1 at cycle 50 after fwd_start. The next frame processes normally.
- rst asserted after 7 pixels -> all outputs at reset values. A following full frame yields the correct class, and mode_train toggled mid-frame has no effect.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: frame-level controller for the CNN accelerator.
// It loads one image (plus a label byte in training mode) into the pixel
// buffer and runs the forward and backward passes through start/done
// handshakes. It reduces the streamed logits to an argmax class and returns
// the result over a valid/ready port, with sticky timeout and logit-count
// error flags.
module cnn_frame_sequencer #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int NUM_CLASSES = 10,
  parameter int LOGIT_W     = 16,
  parameter int TIMEOUT     = 65535,
  localparam int NPIX = IMG_W * IMG_H,
  localparam int AW   = $clog2(NPIX),
  localparam int CW   = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               mode_train,
  input  logic [AW-1:0]      pix_rd_addr,
  output logic [7:0]         pix_rd_data,
  output logic [7:0]         label_out,
  output logic               fwd_start,
  input  logic               fwd_done,
  output logic               bwd_start,
  input  logic               bwd_done,
  input  logic [LOGIT_W-1:0] logit_data,
  input  logic               logit_valid,
  output logic [CW-1:0]      m_class,
  output logic [LOGIT_W-1:0] m_score,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               err_timeout,
  output logic               err_logit,
  input  logic               err_clr,
  output logic [15:0]        frame_cnt
);

  // The logit counter saturates at NUM_CLASSES+1, so it needs room for that value.
  localparam int CNTW = $clog2(NUM_CLASSES + 2);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0]   LAST_PIX_C = AW'(NPIX - 1);
  localparam logic [CNTW-1:0] NC_C       = CNTW'(NUM_CLASSES);
  localparam logic [CNTW-1:0] NC_SAT_C   = CNTW'(NUM_CLASSES + 1);
  localparam logic [TW-1:0]   TMO_LAST_C = TW'(TIMEOUT - 1);
  localparam logic [AW:0]     NPIX_C     = (AW + 1)'(NPIX);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_LABEL = 3'd1,
    ST_FWD   = 3'd2,
    ST_BWD   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic [7:0]                  mem_r [NPIX];
  logic [AW-1:0]               wr_ptr_r;
  logic                        train_r;
  logic [7:0]                  label_r;
  logic [7:0]                  rd_data_r;
  logic                        fwd_start_r, bwd_start_r;
  logic [CNTW-1:0]             cnt_r, cnt_nxt_s;
  logic [CW-1:0]               best_idx_r, best_idx_nxt_s;
  logic signed [LOGIT_W-1:0]   best_score_r, best_score_nxt_s;
  logic [CW-1:0]               m_class_r;
  logic [LOGIT_W-1:0]          m_score_r;
  logic                        err_timeout_r, err_logit_r;
  logic [15:0]                 frame_cnt_r;
  logic [TW-1:0]               wait_cnt_r;
  logic                        xfer_s, train_eff_s, fwd_done_s, bwd_done_s, tmo_s;
  logic                        set_logit_s, set_tmo_s;
  logic                        fwd_entry_s, bwd_entry_s, out_entry_s;

  // s_ready and m_valid come from the state register alone, so no input reaches an output.
  assign s_ready     = (state_r == ST_LOAD) || (state_r == ST_LABEL);
  assign m_valid     = (state_r == ST_OUT);
  assign xfer_s      = s_valid && s_ready;
  // On the first pixel the live mode is the one that will be latched.
  assign train_eff_s = (wr_ptr_r == '0) ? mode_train : train_r;
  // A done that arrives together with the start pulse is ignored.
  assign fwd_done_s  = fwd_done && !fwd_start_r;
  assign bwd_done_s  = bwd_done && !bwd_start_r;
  assign tmo_s       = (wait_cnt_r == TMO_LAST_C);
  assign fwd_entry_s = (state_nxt_s == ST_FWD) && (state_r != ST_FWD);
  assign bwd_entry_s = (state_nxt_s == ST_BWD) && (state_r != ST_BWD);
  assign out_entry_s = (state_nxt_s == ST_OUT) && (state_r != ST_OUT);

  assign pix_rd_data = rd_data_r;
  assign label_out   = label_r;
  assign fwd_start   = fwd_start_r;
  assign bwd_start   = bwd_start_r;
  assign m_class     = m_class_r;
  assign m_score     = m_score_r;
  assign err_timeout = err_timeout_r;
  assign err_logit   = err_logit_r;
  assign frame_cnt   = frame_cnt_r;

  // Running argmax: logit 0 always loads; later logits replace only when strictly greater.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    best_idx_nxt_s   = best_idx_r;
    best_score_nxt_s = best_score_r;
    if ((state_r == ST_FWD) && logit_valid) begin
      if (cnt_r < NC_C) begin
        if ((cnt_r == '0) || ($signed(logit_data) > best_score_r)) begin
          best_idx_nxt_s   = cnt_r[CW-1:0];
          best_score_nxt_s = $signed(logit_data);
        end else begin
          best_idx_nxt_s   = best_idx_r;
          best_score_nxt_s = best_score_r;
        end
      end else begin
        best_idx_nxt_s   = best_idx_r;
        best_score_nxt_s = best_score_r;
      end
      if (cnt_r < NC_SAT_C) begin
        cnt_nxt_s = cnt_r + CNTW'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Next-state decode and error set conditions.
  always_comb begin
    state_nxt_s = state_r;
    set_logit_s = 1'b0;
    set_tmo_s   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (xfer_s && (wr_ptr_r == LAST_PIX_C)) begin
          state_nxt_s = train_eff_s ? ST_LABEL : ST_FWD;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_LABEL: begin
        if (xfer_s) begin
          state_nxt_s = ST_FWD;
        end else begin
          state_nxt_s = ST_LABEL;
        end
      end
      ST_FWD: begin
        if (fwd_done_s) begin
          if (cnt_nxt_s == NC_C) begin
            state_nxt_s = train_r ? ST_BWD : ST_OUT;
          end else begin
            set_logit_s = 1'b1;
            state_nxt_s = ST_LOAD;
          end
        end else if (tmo_s) begin
          set_tmo_s   = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_FWD;
        end
      end
      ST_BWD: begin
        if (bwd_done_s) begin
          state_nxt_s = ST_OUT;
        end else if (tmo_s) begin
          set_tmo_s   = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_BWD;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_LOAD;
    else     state_r <= state_nxt_s;
  end

  // Pixel write pointer and mode latch; a reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      train_r  <= 1'b0;
    end else if ((state_r == ST_LOAD) && xfer_s) begin
      if (wr_ptr_r == '0) train_r <= mode_train;
      if (wr_ptr_r == LAST_PIX_C) wr_ptr_r <= '0;
      else                        wr_ptr_r <= wr_ptr_r + AW'(1);
    end
  end

  // Pixel buffer write port; the contents are not reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && xfer_s) mem_r[wr_ptr_r] <= s_data;
  end

  // Registered read port; a read of the address being written returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rd_data_r <= 8'd0;
    else if ({1'b0, pix_rd_addr} < NPIX_C) rd_data_r <= mem_r[pix_rd_addr];
    else                                  rd_data_r <= 8'd0;
  end

  // Label capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  label_r <= 8'd0;
    else if ((state_r == ST_LABEL) && xfer_s) label_r <= s_data;
  end

  // Logit counter and best-so-far registers, cleared on entry to the forward pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= '0;
      best_idx_r   <= '0;
      best_score_r <= '0;
    end else if (fwd_entry_s) begin
      cnt_r        <= '0;
      best_idx_r   <= '0;
      best_score_r <= '0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      best_idx_r   <= best_idx_nxt_s;
      best_score_r <= best_score_nxt_s;
    end
  end

  // Done-wait counter, restarted on every pass entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          wait_cnt_r <= '0;
    else if (fwd_entry_s || bwd_entry_s)              wait_cnt_r <= '0;
    else if ((state_r == ST_FWD) || (state_r == ST_BWD)) wait_cnt_r <= wait_cnt_r + TW'(1);
  end

  // Start pulses, result capture and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_start_r <= 1'b0;
      bwd_start_r <= 1'b0;
      m_class_r   <= '0;
      m_score_r   <= '0;
      frame_cnt_r <= 16'd0;
    end else begin
      fwd_start_r <= fwd_entry_s;
      bwd_start_r <= bwd_entry_s;
      if (out_entry_s) begin
        m_class_r <= best_idx_nxt_s;
        m_score_r <= best_score_nxt_s;
      end
      if ((state_r == ST_OUT) && m_ready) frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout_r <= 1'b0;
      err_logit_r   <= 1'b0;
    end else begin
      if (set_tmo_s)    err_timeout_r <= 1'b1;
      else if (err_clr) err_timeout_r <= 1'b0;
      if (set_logit_s)  err_logit_r <= 1'b1;
      else if (err_clr) err_logit_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer with a 4x4 image, 10 classes
// and TIMEOUT=50. Expected results come from a plain argmax over a logit
// array, a byte array mirroring the pixel buffer and a frame counter.
module tb_cnn_frame_sequencer;
  localparam int NPIX = 16;
  localparam int NC   = 10;
  localparam int AW   = 4;
  localparam int CW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mode_train;
  logic [AW-1:0] pix_rd_addr;
  logic [7:0]  pix_rd_data;
  logic [7:0]  label_out;
  logic        fwd_start, fwd_done, bwd_start, bwd_done;
  logic [15:0] logit_data;
  logic        logit_valid;
  logic [CW-1:0] m_class;
  logic [15:0] m_score;
  logic        m_valid, m_ready;
  logic        err_timeout, err_logit, err_clr;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  logic [7:0] pix_m [NPIX];
  int logits [NC];

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .IMG_W(4), .IMG_H(4), .NUM_CLASSES(10), .LOGIT_W(16), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mode_train(mode_train), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .label_out(label_out), .fwd_start(fwd_start), .fwd_done(fwd_done),
    .bwd_start(bwd_start), .bwd_done(bwd_done), .logit_data(logit_data),
    .logit_valid(logit_valid), .m_class(m_class), .m_score(m_score),
    .m_valid(m_valid), .m_ready(m_ready), .err_timeout(err_timeout),
    .err_logit(err_logit), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one byte and returns in the cycle after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int k;
    s_valid = 1'b1;
    s_data  = b;
    k = 0;
    while (!s_ready && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) chk("s_ready_wait", 32'(s_ready), 32'd1);
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit train, input bit toggle, input logic [7:0] lab);
    mode_train = train;
    for (int i = 0; i < NPIX; i++) begin
      send_byte(pix_m[i]);
      if (toggle) mode_train = ~mode_train;
    end
    if (train) send_byte(lab);
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < NPIX; i++) pix_m[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_logits(input bit ties);
    for (int i = 0; i < NC; i++) begin
      if (ties) logits[i] = int'($urandom_range(0, 6)) - 3;
      else      logits[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  function automatic int argmax();
    int b = 0;
    for (int i = 1; i < NC; i++) if (logits[i] > logits[b]) b = i;
    return b;
  endfunction

  task automatic feed_logits(input int n, input bit done_with_last);
    for (int i = 0; i < n; i++) begin
      logit_valid = 1'b1;
      if (i < NC) logit_data = logits[i][15:0];
      else        logit_data = 16'h7fff;
      if (done_with_last && (i == n - 1)) fwd_done = 1'b1;
      step(1);
    end
    logit_valid = 1'b0;
    fwd_done    = 1'b0;
  endtask

  task automatic pulse_fwd_done();
    fwd_done = 1'b1;
    step(1);
    fwd_done = 1'b0;
  endtask

  task automatic pulse_bwd_done();
    bwd_done = 1'b1;
    step(1);
    bwd_done = 1'b0;
  endtask

  // Checks the result, holds it for 'hold' cycles, then completes the handshake.
  task automatic finish_out(input int bi, input int hold);
    logic [15:0] sc;
    sc = logits[bi][15:0];
    chk("m_valid", 32'(m_valid), 32'd1);
    chk("m_class", 32'(m_class), 32'(bi));
    chk("m_score", 32'(m_score), 32'(sc));
    m_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step(1);
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_class", 32'(m_class), 32'(bi));
      chk("hold_score", 32'(m_score), 32'(sc));
      chk("hold_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    exp_frames++;
    chk("post_m_valid", 32'(m_valid), 32'd0);
    chk("post_s_ready", 32'(s_ready), 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames[15:0]));
  endtask

  task automatic do_frame(input bit train, input bit combine, input bit ties, input int hold);
    int bi, a, w;
    logic [7:0] lab;
    rand_pixels();
    rand_logits(ties);
    lab = 8'($urandom_range(0, 255));
    send_frame(train, 1'b0, lab);
    chk("fwd_start", 32'(fwd_start), 32'd1);
    chk("s_ready_busy", 32'(s_ready), 32'd0);
    if (train) chk("label_out", 32'(label_out), 32'(lab));
    a = int'($urandom_range(0, NPIX - 1));
    pix_rd_addr = AW'(a);
    step(1);
    chk("pix_rd", 32'(pix_rd_data), 32'(pix_m[a]));
    bi = argmax();
    if (combine) begin
      feed_logits(NC, 1'b1);
    end else begin
      feed_logits(NC, 1'b0);
      pulse_fwd_done();
    end
    if (train) begin
      chk("bwd_start", 32'(bwd_start), 32'd1);
      chk("m_valid_bwd", 32'(m_valid), 32'd0);
      w = int'($urandom_range(1, 3));
      step(w);
      pulse_bwd_done();
    end
    finish_out(bi, hold);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_fwd_start", 32'(fwd_start), 32'd0);
    chk("rst_bwd_start", 32'(bwd_start), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_class", 32'(m_class), 32'd0);
    chk("rst_m_score", 32'(m_score), 32'd0);
    chk("rst_label", 32'(label_out), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_err_logit", 32'(err_logit), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_pix_rd", 32'(pix_rd_data), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi;
    rst = 1'b1; s_data = 8'd0; s_valid = 1'b0; mode_train = 1'b0;
    pix_rd_addr = '0; fwd_done = 1'b0; bwd_done = 1'b0; logit_data = 16'd0;
    logit_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    step(2);
    chk_reset_vals();
    rst = 1'b0;
    step(1);

    // Directed inference: pixels 0..15, tie between classes 2 and 3.
    for (int i = 0; i < NPIX; i++) pix_m[i] = 8'(i);
    logits = '{3, -7, 12, 12, 0, 0, 0, 0, 0, 0};
    send_frame(1'b0, 1'b0, 8'd0);
    chk("inf_fwd_start", 32'(fwd_start), 32'd1);
    pix_rd_addr = AW'(9);
    step(1);
    chk("inf_pix9", 32'(pix_rd_data), 32'd9);
    chk("inf_fwd_start_low", 32'(fwd_start), 32'd0);
    feed_logits(NC, 1'b0);
    chk("inf_no_valid_yet", 32'(m_valid), 32'd0);
    pulse_fwd_done();
    finish_out(2, 2);

    // Directed training with label 5; dones coincident with start pulses are ignored.
    rand_pixels();
    rand_logits(1'b0);
    send_frame(1'b1, 1'b0, 8'h05);
    chk("trn_fwd_start", 32'(fwd_start), 32'd1);
    chk("trn_label", 32'(label_out), 32'd5);
    fwd_done = 1'b1;
    step(1);
    fwd_done = 1'b0;
    chk("trn_early_fdone_err", 32'(err_logit), 32'd0);
    chk("trn_early_fdone_busy", 32'(s_ready), 32'd0);
    chk("trn_early_fdone_bwd", 32'(bwd_start), 32'd0);
    bi = argmax();
    feed_logits(NC, 1'b0);
    pulse_fwd_done();
    chk("trn_bwd_start", 32'(bwd_start), 32'd1);
    chk("trn_m_valid_low", 32'(m_valid), 32'd0);
    pulse_bwd_done();
    chk("trn_early_bdone", 32'(m_valid), 32'd0);
    chk("trn_bwd_start_low", 32'(bwd_start), 32'd0);
    pulse_bwd_done();
    finish_out(bi, 0);

    // All-negative logits held for 20 cycles.
    rand_pixels();
    logits = '{-1, -5, -10, -20, -30, -40, -50, -60, -80, -100};
    send_frame(1'b0, 1'b0, 8'd0);
    feed_logits(NC, 1'b1);
    finish_out(0, 20);

    // Short logit stream raises err_logit and discards the frame.
    rand_pixels();
    rand_logits(1'b0);
    send_frame(1'b0, 1'b0, 8'd0);
    feed_logits(9, 1'b0);
    pulse_fwd_done();
    chk("short_err_logit", 32'(err_logit), 32'd1);
    chk("short_m_valid", 32'(m_valid), 32'd0);
    chk("short_s_ready", 32'(s_ready), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("short_err_clr", 32'(err_logit), 32'd0);

    // Long logit stream with err_clr in the same cycle: set wins.
    rand_pixels();
    send_frame(1'b0, 1'b0, 8'd0);
    feed_logits(11, 1'b0);
    err_clr  = 1'b1;
    fwd_done = 1'b1;
    step(1);
    err_clr  = 1'b0;
    fwd_done = 1'b0;
    chk("long_err_set_wins", 32'(err_logit), 32'd1);
    chk("long_s_ready", 32'(s_ready), 32'd1);
    chk("long_frame_cnt", 32'(frame_cnt), 32'(exp_frames[15:0]));
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("long_err_clr", 32'(err_logit), 32'd0);

    // Timeout: no fwd_done; fires 50 cycles after fwd_start.
    rand_pixels();
    send_frame(1'b0, 1'b0, 8'd0);
    chk("tmo_fwd_start", 32'(fwd_start), 32'd1);
    step(49);
    chk("tmo_not_yet", 32'(err_timeout), 32'd0);
    chk("tmo_still_busy", 32'(s_ready), 32'd0);
    step(1);
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_back_load", 32'(s_ready), 32'd1);
    chk("tmo_no_valid", 32'(m_valid), 32'd0);
    do_frame(1'b0, 1'b0, 1'b0, 1);
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("tmo_clr", 32'(err_timeout), 32'd0);

    // Reset after 7 pixels, then a frame with mode_train toggling mid-frame.
    mode_train = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    step(1);
    rst = 1'b0;
    exp_frames = 0;
    step(1);
    rand_pixels();
    rand_logits(1'b1);
    send_frame(1'b0, 1'b1, 8'd0);
    chk("tgl_fwd_start", 32'(fwd_start), 32'd1);
    chk("tgl_s_ready", 32'(s_ready), 32'd0);
    pix_rd_addr = AW'(0);
    step(1);
    chk("tgl_pix0", 32'(pix_rd_data), 32'(pix_m[0]));
    bi = argmax();
    feed_logits(NC, 1'b0);
    pulse_fwd_done();
    finish_out(bi, 1);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
